mem_stage_wbuf: RTL and testbench

MEM_STAGE_WBUF -- requirements
Module: mem_stage_wbuf

---
 rtl/arm_pkg.sv | 24 ++
 rtl/mem_wbuf.sv | 110 +++++++++++
 rtl/mem_stage_wbuf.sv | 179 +++++++++++++++++
 tb/tb_mem_stage_wbuf.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arm_pkg
// Description : Shared constants and state encoding for the MEM stage with a
//               posted-store write buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package arm_pkg;

   // Default widths and buffer depth used by the MEM stage and write buffer
   localparam int C_DATA_W_DEF     = 32;
   localparam int C_ADDR_W_DEF     = 32;
   localparam int C_DEST_W_DEF     = 4;
   localparam int C_WBUF_DEPTH_DEF = 4;

   // Memory-port controller states
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RD_WAIT = 2'd1,
      ST_WR_WAIT = 2'd2
   } mem_state_e;

endpackage : arm_pkg
`default_nettype wire

// File: rtl/mem_wbuf.sv
`default_nettype none
// ============================================================================
// Module      : mem_wbuf
// Description : Circular write buffer holding posted stores (address, data)
//               with a youngest-match lookup on word address.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_wbuf
   import arm_pkg::*;
#(
   parameter int DATA_W = C_DATA_W_DEF,
   parameter int ADDR_W = C_ADDR_W_DEF,
   parameter int DEPTH  = C_WBUF_DEPTH_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [ADDR_W-1:0] push_addr,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   input  logic [ADDR_W-3:0] lkp_waddr,
   output logic              full,
   output logic              empty,
   output logic [ADDR_W-1:0] head_addr,
   output logic [DATA_W-1:0] head_data,
   output logic              hit,
   output logic [DATA_W-1:0] hit_data
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [PTR_W-1:0]  head_q, head_d;
   logic [PTR_W-1:0]  tail_q, tail_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [ADDR_W-1:0] addr_q [DEPTH];
   logic [ADDR_W-1:0] addr_d [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];
   logic [DATA_W-1:0] data_d [DEPTH];

   logic              do_push;
   logic              do_pop;
   logic [PTR_W-1:0]  idx;

   assign full      = (count_q == CNT_W'(DEPTH));
   assign empty     = (count_q == '0);
   assign head_addr = addr_q[head_q];
   assign head_data = data_q[head_q];

   // A pop in the same cycle frees the slot a push into a full buffer needs
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   // Pointer, count and storage next-state
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      addr_d  = addr_q;
      data_d  = data_q;
      if (do_push) begin
         addr_d[tail_q] = push_addr;
         data_d[tail_q] = push_data;
         tail_d         = tail_q + PTR_W'(1);
      end
      if (do_pop) begin
         head_d = head_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // Scan oldest to youngest so the last match found is the youngest entry
   always_comb begin
      hit      = 1'b0;
      hit_data = '0;
      idx      = head_q;
      for (int i = 0; i < DEPTH; i++) begin
         idx = head_q + PTR_W'(i);
         if ((CNT_W'(i) < count_q) && (addr_q[idx][ADDR_W-1:2] == lkp_waddr)) begin
            hit      = 1'b1;
            hit_data = data_q[idx];
         end
      end
   end

   // Pointers and occupancy; reset empties the buffer
   always_ff @(posedge clk) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Entry storage; contents are only meaningful below count, so no reset
   always_ff @(posedge clk) begin
      addr_q <= addr_d;
      data_q <= data_d;
   end

endmodule : mem_wbuf
`default_nettype wire

// File: rtl/mem_stage_wbuf.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_wbuf
// Description : Pipeline MEM stage. Stores are posted into a write buffer and
//               drained to backing memory; loads are forwarded from the
//               buffer on a hit or fetched from memory on a miss.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage_wbuf
   import arm_pkg::*;
#(
   parameter int DATA_W     = C_DATA_W_DEF,
   parameter int ADDR_W     = C_ADDR_W_DEF,
   parameter int DEST_W     = C_DEST_W_DEF,
   parameter int WBUF_DEPTH = C_WBUF_DEPTH_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wb_en_in,
   input  logic              mem_r_en_in,
   input  logic              mem_w_en_in,
   input  logic [ADDR_W-1:0] alu_res_in,
   input  logic [DATA_W-1:0] val_Rm,
   input  logic [DEST_W-1:0] dest_in,
   output logic              wb_en_out,
   output logic              mem_r_en_out,
   output logic [ADDR_W-1:0] alu_res_out,
   output logic [DEST_W-1:0] dest_out,
   output logic [DATA_W-1:0] mem_out,
   output logic              ready,
   output logic              wbuf_empty,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack
);

   mem_state_e        state_q, state_d;
   logic              mem_req_q, mem_req_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

   logic              ack_v;
   logic              is_load;
   logic              is_store;
   logic              wb_push;
   logic              wb_pop;
   logic              wb_full;
   logic              wb_empty;
   logic              wb_hit;
   logic [DATA_W-1:0] wb_hit_data;
   logic [ADDR_W-1:0] wb_head_addr;
   logic [DATA_W-1:0] wb_head_data;
   logic              rd_done;

   assign wb_en_out    = wb_en_in;
   assign mem_r_en_out = mem_r_en_in;
   assign alu_res_out  = alu_res_in;
   assign dest_out     = dest_in;

   assign mem_req    = mem_req_q;
   assign mem_we     = mem_we_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign wbuf_empty = wb_empty;

   // An ack without an outstanding request (e.g. after reset) is stray
   assign ack_v    = mem_ack & mem_req_q;
   // A load wins when both enables are raised; the store is dropped
   assign is_load  = mem_r_en_in;
   assign is_store = mem_w_en_in & ~mem_r_en_in;
   assign wb_pop   = (state_q == ST_WR_WAIT) & ack_v;
   assign wb_push  = is_store & (~wb_full | wb_pop);
   assign rd_done  = is_load & (state_q == ST_RD_WAIT) & ack_v;

   mem_wbuf #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (WBUF_DEPTH)
   ) u_wbuf (
      .clk       (clk),
      .rst       (rst),
      .push      (wb_push),
      .push_addr (alu_res_in),
      .push_data (val_Rm),
      .pop       (wb_pop),
      .lkp_waddr (alu_res_in[ADDR_W-1:2]),
      .full      (wb_full),
      .empty     (wb_empty),
      .head_addr (wb_head_addr),
      .head_data (wb_head_data),
      .hit       (wb_hit),
      .hit_data  (wb_hit_data)
   );

   // Stall and load-data return toward the pipeline
   always_comb begin
      ready   = 1'b1;
      mem_out = '0;
      if (is_load) begin
         if (wb_hit) begin
            mem_out = wb_hit_data;
         end else if (rd_done) begin
            mem_out = mem_rdata;
         end else begin
            ready = 1'b0;
         end
      end else if (is_store) begin
         ready = wb_push;
      end
   end

   // Memory-port controller next state; request fields held until ack
   always_comb begin
      state_d     = state_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      case (state_q)
         ST_IDLE: begin
            if (is_load && !wb_hit) begin
               state_d     = ST_RD_WAIT;
               mem_req_d   = 1'b1;
               mem_we_d    = 1'b0;
               mem_addr_d  = alu_res_in;
               mem_wdata_d = '0;
            end else if (!wb_empty) begin
               state_d     = ST_WR_WAIT;
               mem_req_d   = 1'b1;
               mem_we_d    = 1'b1;
               mem_addr_d  = wb_head_addr;
               mem_wdata_d = wb_head_data;
            end else if (wb_push) begin
               // Store into an empty buffer becomes the head this edge
               state_d     = ST_WR_WAIT;
               mem_req_d   = 1'b1;
               mem_we_d    = 1'b1;
               mem_addr_d  = alu_res_in;
               mem_wdata_d = val_Rm;
            end
         end
         ST_RD_WAIT, ST_WR_WAIT: begin
            if (ack_v) begin
               state_d   = ST_IDLE;
               mem_req_d = 1'b0;
               mem_we_d  = 1'b0;
            end
         end
         default: begin
            state_d   = ST_IDLE;
            mem_req_d = 1'b0;
            mem_we_d  = 1'b0;
         end
      endcase
   end

   // Controller state and registered memory-port outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

endmodule : mem_stage_wbuf
`default_nettype wire

// File: tb/tb_mem_stage_wbuf.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage_wbuf
// Description : Directed self-checking bench for mem_stage_wbuf.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage_wbuf;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 32;
   localparam int DEST_W = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              wb_en_in, mem_r_en_in, mem_w_en_in;
   logic [ADDR_W-1:0] alu_res_in;
   logic [DATA_W-1:0] val_Rm;
   logic [DEST_W-1:0] dest_in;
   logic              wb_en_out, mem_r_en_out;
   logic [ADDR_W-1:0] alu_res_out;
   logic [DEST_W-1:0] dest_out;
   logic [DATA_W-1:0] mem_out;
   logic              ready, wbuf_empty;
   logic              mem_req, mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ack;

   int n_cmp = 0;
   int n_err = 0;

   mem_stage_wbuf dut (
      .clk          (clk),
      .rst          (rst),
      .wb_en_in     (wb_en_in),
      .mem_r_en_in  (mem_r_en_in),
      .mem_w_en_in  (mem_w_en_in),
      .alu_res_in   (alu_res_in),
      .val_Rm       (val_Rm),
      .dest_in      (dest_in),
      .wb_en_out    (wb_en_out),
      .mem_r_en_out (mem_r_en_out),
      .alu_res_out  (alu_res_out),
      .dest_out     (dest_out),
      .mem_out      (mem_out),
      .ready        (ready),
      .wbuf_empty   (wbuf_empty),
      .mem_req      (mem_req),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata),
      .mem_ack      (mem_ack)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      wb_en_in    = 1'b0;
      mem_r_en_in = 1'b0;
      mem_w_en_in = 1'b0;
      alu_res_in  = '0;
      val_Rm      = '0;
      dest_in     = '0;
   endtask

   task automatic set_store(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      idle_in();
      mem_w_en_in = 1'b1;
      alu_res_in  = a;
      val_Rm      = d;
   endtask

   task automatic set_load(input logic [ADDR_W-1:0] a);
      idle_in();
      wb_en_in    = 1'b1;
      mem_r_en_in = 1'b1;
      alu_res_in  = a;
   endtask

   // Acknowledge every request until the buffer and port are idle
   task automatic drain(input string tag);
      int n;
      n = 0;
      while ((!wbuf_empty || mem_req) && n < 64) begin
         mem_ack = mem_req;
         cyc();
         n++;
      end
      mem_ack = 1'b0;
      chk({tag, "_drained"}, 64'(n < 64), 64'd1);
   endtask

   initial begin
      idle_in();
      rst       = 1'b1;
      mem_ack   = 1'b0;
      mem_rdata = '0;
      cyc();
      cyc();
      rst = 1'b0;

      // Reset state
      @(negedge clk);
      chk("rst_empty", 64'(wbuf_empty), 64'd1);
      chk("rst_req",   64'(mem_req),    64'd0);
      chk("rst_we",    64'(mem_we),     64'd0);
      chk("rst_addr",  64'(mem_addr),   64'd0);
      chk("rst_wdata", 64'(mem_wdata),  64'd0);
      chk("rst_ready", 64'(ready),      64'd1);
      chk("rst_mout",  64'(mem_out),    64'd0);
      cyc();

      // S1: posted store to an idle memory
      set_store(32'h100, 32'hDEADBEEF);
      wb_en_in = 1'b1;
      dest_in  = 4'd5;
      @(negedge clk);
      chk("s1_ready",   64'(ready),       64'd1);
      chk("s1_req_pre", 64'(mem_req),     64'd0);
      chk("s1_dest",    64'(dest_out),    64'd5);
      chk("s1_alu",     64'(alu_res_out), 64'h100);
      chk("s1_wben",    64'(wb_en_out),   64'd1);
      cyc();
      idle_in();
      chk("s1_req",   64'(mem_req),    64'd1);
      chk("s1_we",    64'(mem_we),     64'd1);
      chk("s1_addr",  64'(mem_addr),   64'h100);
      chk("s1_wdata", 64'(mem_wdata),  64'hDEADBEEF);
      chk("s1_nempty", 64'(wbuf_empty), 64'd0);
      mem_ack = 1'b1;
      cyc();
      mem_ack = 1'b0;
      chk("s1_req_done", 64'(mem_req),    64'd0);
      chk("s1_empty",    64'(wbuf_empty), 64'd1);

      // S2: load forwarded from an entry that is still draining
      set_store(32'h200, 32'h11);
      cyc();
      set_load(32'h202);
      @(negedge clk);
      chk("s2_mout",  64'(mem_out), 64'h11);
      chk("s2_ready", 64'(ready),   64'd1);
      chk("s2_rdout", 64'(mem_r_en_out), 64'd1);
      cyc();
      idle_in();
      chk("s2_noread", 64'(mem_req & ~mem_we), 64'd0);
      drain("s2");

      // S3: youngest matching entry wins
      set_store(32'h300, 32'd1);
      cyc();
      set_store(32'h300, 32'd2);
      cyc();
      set_load(32'h300);
      @(negedge clk);
      chk("s3_mout",  64'(mem_out), 64'd2);
      chk("s3_ready", 64'(ready),   64'd1);
      cyc();
      idle_in();
      drain("s3");

      // S4: full buffer stalls a fifth store until the first pop
      for (int i = 0; i < 4; i++) begin
         set_store(32'h500 + 32'(4 * i), 32'hA0 + 32'(i));
         @(negedge clk);
         chk($sformatf("s4_fill%0d", i), 64'(ready), 64'd1);
         cyc();
      end
      set_store(32'h510, 32'hA4);
      @(negedge clk);
      chk("s4_stall0", 64'(ready), 64'd0);
      cyc();
      @(negedge clk);
      chk("s4_stall1", 64'(ready), 64'd0);
      chk("s4_head",   64'(mem_addr), 64'h500);
      cyc();
      mem_ack = 1'b1;
      @(negedge clk);
      chk("s4_accept", 64'(ready), 64'd1);
      cyc();
      mem_ack = 1'b0;
      set_load(32'h510);
      @(negedge clk);
      chk("s4_fwd5",  64'(mem_out), 64'hA4);
      chk("s4_rdy5",  64'(ready),   64'd1);
      cyc();
      idle_in();
      drain("s4");

      // S5: load miss serviced by memory, acked on the third request cycle
      mem_rdata = 32'hCAFE;
      set_load(32'h400);
      @(negedge clk);
      chk("s5_stall0", 64'(ready),   64'd0);
      chk("s5_mout0",  64'(mem_out), 64'd0);
      cyc();
      chk("s5_req",  64'(mem_req),  64'd1);
      chk("s5_we",   64'(mem_we),   64'd0);
      chk("s5_addr", 64'(mem_addr), 64'h400);
      @(negedge clk);
      chk("s5_stall1", 64'(ready), 64'd0);
      cyc();
      @(negedge clk);
      chk("s5_stall2", 64'(ready), 64'd0);
      cyc();
      mem_ack = 1'b1;
      @(negedge clk);
      chk("s5_ready", 64'(ready),   64'd1);
      chk("s5_mout",  64'(mem_out), 64'hCAFE);
      cyc();
      mem_ack = 1'b0;
      idle_in();
      chk("s5_req_done", 64'(mem_req), 64'd0);
      mem_rdata = '0;

      // Illegal load+store: store dropped, load serviced
      set_load(32'h700);
      mem_w_en_in = 1'b1;
      val_Rm      = 32'h77;
      @(negedge clk);
      chk("ill_stall", 64'(ready), 64'd0);
      cyc();
      chk("ill_rd", 64'(mem_we), 64'd0);
      mem_rdata = 32'h55;
      mem_ack   = 1'b1;
      @(negedge clk);
      chk("ill_mout", 64'(mem_out), 64'h55);
      cyc();
      mem_ack = 1'b0;
      idle_in();
      chk("ill_empty", 64'(wbuf_empty), 64'd1);

      // S6: reset during a drain with two entries buffered
      set_store(32'h600, 32'h60);
      cyc();
      set_store(32'h604, 32'h64);
      cyc();
      idle_in();
      chk("s6_inflight", 64'(mem_req), 64'd1);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      chk("s6_req",   64'(mem_req),    64'd0);
      chk("s6_empty", 64'(wbuf_empty), 64'd1);
      mem_ack = 1'b1;
      cyc();
      mem_ack = 1'b0;
      chk("s6_late_req",   64'(mem_req),    64'd0);
      chk("s6_late_empty", 64'(wbuf_empty), 64'd1);
      cyc();
      chk("s6_no_drain", 64'(mem_req), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // Bound on total run time
   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule : tb_mem_stage_wbuf
`default_nettype wire
